// File: rtl/fetch_stage.sv
// fetch_stage: registers instruction, PC and valid bit into the IF/ID boundary.
// Handles stall hold, flush bubbles and suppression of the post-reset sentinel PC.
// Optional macro FETCH_STATS_EN adds saturating fetch/bubble counters.
module fetch_stage #(
  parameter int          ADDR_W    = 6,
  parameter int          DEPTH     = 64,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       bubble_count
`endif
);

  // PRIME waits for the sentinel PC to pass; RUN fetches normally
  typedef enum logic {PRIME, RUN} state_e;

  state_e              state_q, state_d;
  logic [31:0]         mem [DEPTH];
  logic [31:0]         rd_data;
  logic [31:0]         instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic                capture;

  // Instruction store write port: active in every state and never cleared by reset
  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  assign rd_data = mem[pc];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= PRIME;
    else       state_q <= state_d;
  end

  // Next state: a load restarts priming, leaving PRIME needs a non-stalled edge
  always_comb begin
    state_d = state_q;
    if (load_en)                         state_d = PRIME;
    else if (state_q == PRIME && !stall) state_d = RUN;
  end

  // Output decision: capture=0 means hold the IF/ID contents; default capture is a bubble
  always_comb begin
    capture       = 1'b0;
    instr_d       = NOP_INSTR;
    instr_pc_d    = pc;
    instr_valid_d = 1'b0;
    if (load_en) begin
      capture = 1'b1;
    end else if (state_q == PRIME) begin
      capture = !stall;
    end else if (flush) begin
      capture = 1'b1;
    end else if (!stall) begin
      capture       = 1'b1;
      instr_d       = rd_data;
      instr_valid_d = 1'b1;
    end
  end

  // IF/ID boundary register, reset to a bubble carrying the sentinel PC
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= {ADDR_W{1'b1}};
      instr_valid_q <= 1'b0;
    end else if (capture) begin
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] bubble_count_q, bubble_count_d;

  // Count each capturing edge as a fetch or a bubble; holds count neither; saturate
  always_comb begin
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;
    if (capture && instr_valid_d && fetch_count_q != 16'hFFFF)
      fetch_count_d = fetch_count_q + 16'd1;
    if (capture && !instr_valid_d && bubble_count_q != 16'hFFFF)
      bubble_count_d = bubble_count_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count_q  <= 16'd0;
      bubble_count_q <= 16'd0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage, checked every cycle against
// a behavioural model plus hand-computed literal expectations.
module tb_fetch_stage;

  localparam int          ADDR_W = 6;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] pc;
  logic              stall;
  logic              flush;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
`ifdef FETCH_STATS_EN
  logic [15:0]       fetch_count;
  logic [15:0]       bubble_count;
`endif

  int vec_count = 0;
  int err_count = 0;
  bit check_en  = 1'b0;

  // Behavioural model state
  logic [31:0]       mdl_mem [64];
  bit                mdl_awaiting_sentinel;
  logic [31:0]       mdl_instr;
  logic [ADDR_W-1:0] mdl_pc;
  logic              mdl_valid;
  int                mdl_fetches;
  int                mdl_bubbles;

  fetch_stage #(.ADDR_W(ADDR_W), .DEPTH(64), .NOP_INSTR(NOP)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .stall       (stall),
    .flush       (flush),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count (fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clock = ~clock;

  // One comparison: counts it and reports a failure line on mismatch
  task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model reset: bubble with sentinel PC, waiting for the sentinel to pass
  task automatic modelReset();
    mdl_instr             = NOP;
    mdl_pc                = 6'd63;
    mdl_valid             = 1'b0;
    mdl_awaiting_sentinel = 1'b1;
    mdl_fetches           = 0;
    mdl_bubbles           = 0;
  endtask

  // Model of one rising edge, from the fetch rules: 0 hold, 1 bubble, 2 fetch
  task automatic modelEdge(input logic [5:0] a_pc, input bit a_stall, input bit a_flush,
                           input bit a_ld, input logic [5:0] a_la, input logic [31:0] a_ld_data);
    int outcome;
    if (!reset) begin
      if (a_ld) begin
        outcome = 1;
        mdl_awaiting_sentinel = 1'b1;
      end else if (mdl_awaiting_sentinel) begin
        outcome = a_stall ? 0 : 1;
        if (!a_stall) mdl_awaiting_sentinel = 1'b0;
      end else if (a_flush) outcome = 1;
      else if (a_stall)     outcome = 0;
      else                  outcome = 2;
      if (outcome == 2) begin
        mdl_instr = mdl_mem[a_pc];
        mdl_pc    = a_pc;
        mdl_valid = 1'b1;
        if (mdl_fetches < 65535) mdl_fetches++;
      end else if (outcome == 1) begin
        mdl_instr = NOP;
        mdl_pc    = a_pc;
        mdl_valid = 1'b0;
        if (mdl_bubbles < 65535) mdl_bubbles++;
      end
    end
    if (a_ld) mdl_mem[a_la] = a_ld_data;
  endtask

  // Drive one cycle of inputs, step the model on the edge, return 1 ns later
  task automatic applyStimulus(input logic [5:0] a_pc, input bit a_stall, input bit a_flush,
                               input bit a_ld, input logic [5:0] a_la, input logic [31:0] a_ld_data);
    pc        = a_pc;
    stall     = a_stall;
    flush     = a_flush;
    load_en   = a_ld;
    load_addr = a_la;
    load_data = a_ld_data;
    @(posedge clock);
    modelEdge(a_pc, a_stall, a_flush, a_ld, a_la, a_ld_data);
    #1;
  endtask

  // Hand-computed literal expectation on the IF/ID outputs
  task automatic checkOutput(input logic [31:0] e_instr, input logic [5:0] e_pc, input logic e_valid);
    compareField("lit_instr", instr, e_instr);
    compareField("lit_instr_pc", {26'd0, instr_pc}, {26'd0, e_pc});
    compareField("lit_instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
  endtask

`ifdef FETCH_STATS_EN
  // Hand-computed literal expectation on the statistics counters
  task automatic checkStats(input int e_fetch, input int e_bubble);
    compareField("lit_fetch_count", {16'd0, fetch_count}, e_fetch);
    compareField("lit_bubble_count", {16'd0, bubble_count}, e_bubble);
  endtask
`endif

  // Every falling edge: DUT outputs against the model
  always @(negedge clock) begin
    if (check_en) begin
      compareField("instr", instr, mdl_instr);
      compareField("instr_pc", {26'd0, instr_pc}, {26'd0, mdl_pc});
      compareField("instr_valid", {31'd0, instr_valid}, {31'd0, mdl_valid});
`ifdef FETCH_STATS_EN
      compareField("fetch_count", {16'd0, fetch_count}, mdl_fetches);
      compareField("bubble_count", {16'd0, bubble_count}, mdl_bubbles);
`endif
    end
  end

  initial begin
    reset     = 1'b1;
    pc        = 6'd63;
    stall     = 1'b0;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = 6'd0;
    load_data = 32'd0;
    modelReset();
    #1;
    check_en = 1'b1;
    $display("[TB] reset and store load");
    checkOutput(NOP, 6'd63, 1'b0);

    applyStimulus(6'd63, 0, 0, 1, 6'd0,  32'h00100093);
    applyStimulus(6'd63, 0, 0, 1, 6'd1,  32'h00200113);
    applyStimulus(6'd63, 0, 0, 1, 6'd2,  32'h00300193);
    applyStimulus(6'd63, 0, 0, 1, 6'd3,  32'h00400213);
    applyStimulus(6'd63, 0, 0, 1, 6'd63, 32'h3F000093);
    checkOutput(NOP, 6'd63, 1'b0);
    reset = 1'b0;

    $display("[TB] sentinel bubble then fetch");
    applyStimulus(6'd63, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(NOP, 6'd63, 1'b0);
    applyStimulus(6'd0, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(32'h00100093, 6'd0, 1'b1);
    applyStimulus(6'd1, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(32'h00200113, 6'd1, 1'b1);
    applyStimulus(6'd2, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(32'h00300193, 6'd2, 1'b1);
`ifdef FETCH_STATS_EN
    checkStats(3, 1);
`endif

    $display("[TB] stall hold");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'd2, 1, 0, 0, 6'd0, 32'd0);
      checkOutput(32'h00300193, 6'd2, 1'b1);
    end
`ifdef FETCH_STATS_EN
    checkStats(3, 1);
`endif
    applyStimulus(6'd3, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(32'h00400213, 6'd3, 1'b1);

    $display("[TB] flush over stall");
    applyStimulus(6'd1, 1, 1, 0, 6'd0, 32'd0);
    checkOutput(NOP, 6'd1, 1'b0);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(6'd0, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(32'h00100093, 6'd0, 1'b1);
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput(NOP, 6'd63, 1'b0);
`ifdef FETCH_STATS_EN
    checkStats(0, 0);
`endif
    #1;
    reset = 1'b0;
    applyStimulus(6'd63, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(NOP, 6'd63, 1'b0);
    applyStimulus(6'd0, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(32'h00100093, 6'd0, 1'b1);

    $display("[TB] load during run");
    applyStimulus(6'd1, 0, 0, 1, 6'd5, 32'hDEADBEEF);
    checkOutput(NOP, 6'd1, 1'b0);
    applyStimulus(6'd2, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(NOP, 6'd2, 1'b0);
    applyStimulus(6'd5, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(32'hDEADBEEF, 6'd5, 1'b1);

    $display("[TB] write/read collision, stall while priming, pc 63 and wrap");
    applyStimulus(6'd6, 0, 0, 1, 6'd6, 32'hCAFEF00D);
    checkOutput(NOP, 6'd6, 1'b0);
    applyStimulus(6'd7, 1, 0, 0, 6'd0, 32'd0);
    checkOutput(NOP, 6'd6, 1'b0);
    applyStimulus(6'd7, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(NOP, 6'd7, 1'b0);
    applyStimulus(6'd6, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(32'hCAFEF00D, 6'd6, 1'b1);
    applyStimulus(6'd63, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(32'h3F000093, 6'd63, 1'b1);
    applyStimulus(6'd0, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(32'h00100093, 6'd0, 1'b1);

    $display("[TB] flush without stall");
    applyStimulus(6'd1, 0, 1, 0, 6'd0, 32'd0);
    checkOutput(NOP, 6'd1, 1'b0);
    applyStimulus(6'd2, 0, 0, 0, 6'd0, 32'd0);
    checkOutput(32'h00300193, 6'd2, 1'b1);

    @(negedge clock);
    #1;
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
